// File: rtl/store_io_pkg.sv
// Shared opcode, funct3, memory-map constants and the store byte-mask helper
// for the store/IO unit.
package store_io_pkg;

    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [2:0] F3_SB = 3'd0;
    localparam logic [2:0] F3_SH = 3'd1;
    localparam logic [2:0] F3_SW = 3'd2;

    localparam logic [31:0] MMIO_TX_OFF  = 32'h0000_0008;
    localparam logic [31:0] MMIO_CLR_OFF = 32'h0000_0018;

    // Region decode on addr[31:28]: DMEM = 4'b00x1, IMEM = 4'b001x (they overlap at 4'b0011).
    localparam logic [3:0] DMEM_NIB_MASK = 4'b1101;
    localparam logic [3:0] DMEM_NIB_VAL  = 4'b0001;
    localparam logic [3:0] IMEM_NIB_MASK = 4'b1110;
    localparam logic [3:0] IMEM_NIB_VAL  = 4'b0010;

    typedef enum logic {
        TX_EMPTY = 1'b0,
        TX_FULL  = 1'b1
    } tx_state_e;

    function automatic logic [3:0] byte_mask(input logic [2:0] funct3, input logic [1:0] off);
        logic [3:0] m;
        case (funct3)
            F3_SB:   m = 4'b0001 << off;
            F3_SH:   m = 4'b0011 << off;
            F3_SW:   m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/store_io_unit_tx_buffer.sv
// Single-entry UART transmit buffer; a new byte may be loaded in the same
// cycle the held byte is drained, so back-to-back traffic never bubbles.
module uart_tx_buffer
    import store_io_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid_i,
    input  logic [7:0] in_data_i,
    output logic       in_ready_o,
    output logic       out_valid_o,
    output logic [7:0] out_data_o,
    input  logic       out_ready_i
);

    tx_state_e  state_q, state_d;
    logic [7:0] data_q, data_d;
    logic       accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= TX_EMPTY;
            data_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        if (accept) begin
            state_d = TX_FULL;
            data_d  = in_data_i;
        end else if (state_q == TX_FULL && out_ready_i) begin
            state_d = TX_EMPTY;
        end
    end

    always_comb begin
        out_valid_o = (state_q == TX_FULL);
        in_ready_o  = (state_q == TX_EMPTY) || out_ready_i;
        accept      = in_valid_i && in_ready_o;
    end

    assign out_data_o = data_q;

endmodule

// File: rtl/store_io_unit.sv
// Store path of the execute stage: byte masking, DMEM/IMEM/MMIO decode,
// UART transmit buffer and free-running cycle/retired-instruction counters.
module store_io_unit
    import store_io_pkg::*;
#(
    parameter logic [31:0] IO_BASE = 32'h8000_0000,
    parameter int          CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      inst_ex_i,
    input  logic             inst_valid_i,
    input  logic [31:0]      addr_i,
    input  logic [31:0]      rs2_data_i,
    input  logic             retire_i,
    input  logic             uart_tx_ready_i,
    output logic [3:0]       dmem_we_o,
    output logic [3:0]       imem_we_o,
    output logic [31:0]      wdata_o,
    output logic [7:0]       uart_tx_data_o,
    output logic             uart_tx_valid_o,
    output logic [CNT_W-1:0] cycle_cnt_o,
    output logic [CNT_W-1:0] inst_cnt_o,
    output logic             stall_o
);

    logic             is_store, dmem_hit, imem_hit, tx_store, clr_store, tx_in_ready;
    logic [3:0]       mask;
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d, inst_cnt_q, inst_cnt_d;

    always_comb begin
        is_store  = inst_valid_i && (inst_ex_i[6:0] == OPC_STORE);
        mask      = byte_mask(inst_ex_i[14:12], addr_i[1:0]);
        dmem_hit  = (addr_i[31:28] & DMEM_NIB_MASK) == DMEM_NIB_VAL;
        imem_hit  = (addr_i[31:28] & IMEM_NIB_MASK) == IMEM_NIB_VAL;
        tx_store  = is_store && (addr_i == IO_BASE + MMIO_TX_OFF);
        clr_store = is_store && (addr_i == IO_BASE + MMIO_CLR_OFF);
        stall_o   = tx_store && !tx_in_ready;
        dmem_we_o = (is_store && dmem_hit && !stall_o) ? mask : 4'b0000;
        imem_we_o = (is_store && imem_hit && !stall_o) ? mask : 4'b0000;
        wdata_o   = rs2_data_i << {addr_i[1:0], 3'b000};
    end

    uart_tx_buffer u_tx_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (tx_store),
        .in_data_i   (rs2_data_i[7:0]),
        .in_ready_o  (tx_in_ready),
        .out_valid_o (uart_tx_valid_o),
        .out_data_o  (uart_tx_data_o),
        .out_ready_i (uart_tx_ready_i)
    );

    // Clear wins over the same-cycle increment.
    always_comb begin
        cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
        inst_cnt_d  = retire_i ? inst_cnt_q + CNT_W'(1) : inst_cnt_q;
        if (clr_store) begin
            cycle_cnt_d = '0;
            inst_cnt_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt_q <= '0;
            inst_cnt_q  <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_d;
            inst_cnt_q  <= inst_cnt_d;
        end
    end

    assign cycle_cnt_o = cycle_cnt_q;
    assign inst_cnt_o  = inst_cnt_q;

endmodule
